ps2_key_sequencer: RTL

- Sequences a PS/2 receiver FIFO: pops scan-code bytes with an active-low one-cycle handshake and decodes the E0 (extended) and F0 (break) prefixes.
- Tracks the single displayed key, its held status and a press count.
- Filters typematic repeats and recovers from truncated prefix sequences.
- Sits between the PS/2 receiver and the segment-display driver; key_held directly gates the segment enable.

---
 rtl/ps2_key_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
// ------------------
// Pops scan-code bytes from the PS/2 receiver FIFO and decodes the E0
// (extended) and F0 (break) prefixes. It tracks the one key shown on the
// segment display: its code, whether it was extended, whether it is still
// held, and how many distinct presses have been seen.
//
// Each byte goes through three states, IDLE -> POP -> EVAL -> IDLE. The
// receiver therefore gets the EVAL cycle to update ps2_ready before it is
// sampled again.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-low reset
//   ps2_ready      receiver FIFO non-empty
//   ps2_data       FIFO head byte, valid while ps2_ready is high
//   ps2_overflow   receiver FIFO overflow (level)
//   clr_cnt        synchronous clear of press_cnt and ovf_flag
//   ps2_nextdata_n active-low pop strobe, one cycle per byte
//   key_code       scan code of the displayed key
//   key_ext        displayed key was E0-prefixed
//   key_held       displayed key currently pressed (segment enable)
//   press_cnt      count of new key presses, wraps
//   make_pulse     one-cycle strobe: new key registered
//   break_pulse    one-cycle strobe: displayed key released
//   timeout_pulse  one-cycle strobe: pending prefix discarded
//   ovf_flag       sticky overflow indicator
module ps2_key_sequencer #(
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ps2_ready,
   input  logic [7:0]       ps2_data,
   input  logic             ps2_overflow,
   input  logic             clr_cnt,
   output logic             ps2_nextdata_n,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_held,
   output logic [CNT_W-1:0] press_cnt,
   output logic             make_pulse,
   output logic             break_pulse,
   output logic             timeout_pulse,
   output logic             ovf_flag
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      POP  = 3'b010,
      EVAL = 3'b100
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             nextdata_n_q, nextdata_n_d;
   logic [7:0]       key_code_q, key_code_d;
   logic             key_ext_q, key_ext_d;
   logic             key_held_q, key_held_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic             make_q, make_d;
   logic             break_q, break_d;
   logic             timeout_q, timeout_d;
   logic             ovf_q, ovf_d;
   logic             ext_pend_q, ext_pend_d;
   logic             brk_pend_q, brk_pend_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic             same_key;

   // The byte matches the displayed key only if both the code and the
   // extended flag agree and the key is still down.
   assign same_key = key_held_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

   // Next-state logic. Pulses default low so each lasts exactly one cycle.
   // make/break come only from EVAL and timeout only from IDLE, so they
   // can never overlap.
   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      nextdata_n_d = 1'b1;
      key_code_d   = key_code_q;
      key_ext_d    = key_ext_q;
      key_held_d   = key_held_q;
      press_cnt_d  = press_cnt_q;
      make_d       = 1'b0;
      break_d      = 1'b0;
      timeout_d    = 1'b0;
      ovf_d        = ovf_q;
      ext_pend_d   = ext_pend_q;
      brk_pend_d   = brk_pend_q;
      tmo_cnt_d    = '0;

      case (state_q)
         IDLE: begin
            if (ps2_ready) begin
               byte_d       = ps2_data;
               nextdata_n_d = 1'b0;
               state_d      = POP;
            end else if ((ext_pend_q || brk_pend_q) && !ps2_overflow) begin
               // A prefix with no follow-up byte is dropped after the idle budget.
               if (tmo_cnt_q == TMO_LAST) begin
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
                  timeout_d  = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TW'(1);
               end
            end
            // After an overflow a partially received sequence cannot be trusted.
            if (ps2_overflow) begin
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
            end
         end
         POP: begin
            state_d = EVAL;
         end
         EVAL: begin
            state_d = IDLE;
            if (byte_q == 8'hE0) begin
               ext_pend_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
               brk_pend_d = 1'b1;
            end else begin
               if (brk_pend_q) begin
                  if (same_key) begin
                     key_held_d = 1'b0;
                     break_d    = 1'b1;
                  end
               end else if (!same_key) begin
                  // Typematic repeats of the held key fall through unchanged.
                  key_code_d  = byte_q;
                  key_ext_d   = ext_pend_q;
                  key_held_d  = 1'b1;
                  press_cnt_d = press_cnt_q + CNT_W'(1);
                  make_d      = 1'b1;
               end
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // clr_cnt beats a same-cycle increment, and overflow beats clr_cnt for the flag.
      if (clr_cnt) begin
         press_cnt_d = '0;
         ovf_d       = 1'b0;
      end
      if (ps2_overflow) begin
         ovf_d = 1'b1;
      end
   end

   // All state and outputs are registered here. Reset releases the pop
   // strobe at once, so a byte in flight is never popped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         byte_q       <= '0;
         nextdata_n_q <= 1'b1;
         key_code_q   <= '0;
         key_ext_q    <= 1'b0;
         key_held_q   <= 1'b0;
         press_cnt_q  <= '0;
         make_q       <= 1'b0;
         break_q      <= 1'b0;
         timeout_q    <= 1'b0;
         ovf_q        <= 1'b0;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         tmo_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         byte_q       <= byte_d;
         nextdata_n_q <= nextdata_n_d;
         key_code_q   <= key_code_d;
         key_ext_q    <= key_ext_d;
         key_held_q   <= key_held_d;
         press_cnt_q  <= press_cnt_d;
         make_q       <= make_d;
         break_q      <= break_d;
         timeout_q    <= timeout_d;
         ovf_q        <= ovf_d;
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   assign ps2_nextdata_n = nextdata_n_q;
   assign key_code       = key_code_q;
   assign key_ext        = key_ext_q;
   assign key_held       = key_held_q;
   assign press_cnt      = press_cnt_q;
   assign make_pulse     = make_q;
   assign break_pulse    = break_q;
   assign timeout_pulse  = timeout_q;
   assign ovf_flag       = ovf_q;

endmodule
